// File: rtl/regfile_burst_reader.sv
// regfile_burst_reader
// Read-side sequencer for a single-read-port register file. A start command
// walks `count` consecutive addresses from `start_addr`, wrapping modulo
// 2^ADDR_WIDTH. Each word is presented on a registered valid/ready stream, and
// the final word is marked with out_last.
//
// Ports
//   CLK           rising-edge clock
//   ASYNCRESET    asynchronous reset, active-high
//   start         burst request, only looked at while idle
//   start_addr    first address of the burst
//   count         number of words (0 = empty burst, done only)
//   busy          burst in progress
//   done          one-cycle pulse after the burst completes
//   rf_read_addr  regfile read address (registered pointer)
//   rf_read_data  regfile read data (combinational, with write bypass)
//   out_data      stream data
//   out_valid     stream valid
//   out_ready     stream ready
//   out_last      final word of the burst
//
// state | meaning
// IDLE  | waiting for start; rf_read_addr holds its last value
// READ  | fetching words into the output register as it frees up
// DRAIN | final word is held until the consumer takes it
module regfile_burst_reader #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESET,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] REM_ONE  = 1;
    localparam logic [ADDR_WIDTH:0] REM_ZERO = '0;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_n;
    logic [ADDR_WIDTH:0]     remaining, remaining_n;
    logic [DATA_WIDTH-1:0]   data_n;
    logic                    valid_n, last_n, done_n;
    logic                    capture;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            remaining <= remaining_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            done      <= done_n;
        end
    end

    // The output register can take a new word when it is empty or its current
    // word is being consumed on this edge.
    assign capture = !out_valid || out_ready;

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        remaining_n = remaining;
        data_n      = out_data;
        valid_n     = out_valid;
        last_n      = out_last;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (count != REM_ZERO) begin
                        ptr_n       = start_addr;
                        remaining_n = count;
                        state_n     = READ;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            READ: begin
                if (capture) begin
                    data_n      = rf_read_data;
                    valid_n     = 1'b1;
                    last_n      = (remaining == REM_ONE);
                    ptr_n       = ptr + 1'b1;
                    remaining_n = remaining - 1'b1;
                    if (remaining == REM_ONE) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign rf_read_addr = ptr;

endmodule
